// File: rtl/uart_pkg.sv
// Shared definitions for the UART packet controller: FSM states,
// error cause codes and the default frame start marker.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHK     = 3'd4,
    ST_COMMIT  = 3'd5
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CHK     = 2'b01;
  localparam logic [1:0] ERR_LEN     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/pkt_buf.sv
// Payload buffer: DEPTH x 8 storage with one write port and one read
// port; read data is registered (one clock latency), no reset needed.
module pkt_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  // Synchronous write and registered read.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_pkt_ctrl.sv
// Frame parser for a UART byte stream: SYNC, ADDR, LEN, payload, CHK.
// A checked frame is replayed into the register file one byte per clock;
// malformed or stalled frames are discarded with an error cause.
module uart_pkt_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       pkt_done,
  output logic       pkt_err,
  output logic [1:0] err_code,
  output logic       busy,
  output logic       rx_drop
);

  // idx must reach LEN itself (end-of-commit marker), hence MAX_LEN+1.
  localparam int IW  = $clog2(MAX_LEN + 1);
  localparam int BAW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [IW-1:0] MAX_LEN_W = IW'(MAX_LEN);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

  state_e        state_q, state_d;
  logic [7:0]    base_q, base_d;
  logic [IW-1:0] len_q, len_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    xor_q, xor_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic          wr_en_q, wr_en_d;
  logic [7:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          pkt_done_q, pkt_done_d;
  logic          pkt_err_q, pkt_err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          busy_q;
  logic          rx_drop_q, rx_drop_d;

  logic           buf_we;
  logic [BAW-1:0] buf_raddr;
  logic [7:0]     buf_rdata;

  // Next-state and registered-output logic for the frame FSM.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    idx_d      = idx_q;
    xor_d      = xor_q;
    tmo_d      = tmo_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    pkt_done_d = 1'b0;
    pkt_err_d  = 1'b0;
    err_code_d = ERR_NONE;
    rx_drop_d  = 1'b0;
    buf_we     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          xor_d   = '0;
          state_d = ST_ADDR;
        end
      end

      ST_ADDR, ST_LEN, ST_PAYLOAD, ST_CHK: begin
        if (rx_valid) begin
          // An arriving byte always wins over a simultaneous timeout.
          tmo_d = '0;
          case (state_q)
            ST_ADDR: begin
              base_d  = rx_data;
              xor_d   = rx_data;
              state_d = ST_LEN;
            end
            ST_LEN: begin
              if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
                pkt_err_d  = 1'b1;
                err_code_d = ERR_LEN;
                state_d    = ST_IDLE;
              end else begin
                len_d   = IW'(rx_data);
                xor_d   = xor_q ^ rx_data;
                idx_d   = '0;
                state_d = ST_PAYLOAD;
              end
            end
            ST_PAYLOAD: begin
              buf_we = 1'b1;
              xor_d  = xor_q ^ rx_data;
              idx_d  = idx_q + 1'b1;
              if (idx_q == len_q - 1'b1) begin
                state_d = ST_CHK;
              end
            end
            default: begin
              if (rx_data == xor_q) begin
                idx_d   = '0;
                state_d = ST_COMMIT;
              end else begin
                pkt_err_d  = 1'b1;
                err_code_d = ERR_CHK;
                state_d    = ST_IDLE;
              end
            end
          endcase
        end else if (tmo_q == TO_LAST) begin
          pkt_err_d  = 1'b1;
          err_code_d = ERR_TIMEOUT;
          tmo_d      = '0;
          state_d    = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      ST_COMMIT: begin
        rx_drop_d = rx_valid;
        if (idx_q == len_q) begin
          pkt_done_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = base_q + 8'(idx_q);
          wr_data_d = buf_rdata;
          idx_d     = idx_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Read one entry ahead so buffer data is ready when its write is issued.
  always_comb begin
    buf_raddr = '0;
    if (idx_d < MAX_LEN_W) begin
      buf_raddr = BAW'(idx_d);
    end
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      xor_q      <= '0;
      tmo_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      pkt_done_q <= 1'b0;
      pkt_err_q  <= 1'b0;
      err_code_q <= ERR_NONE;
      busy_q     <= 1'b0;
      rx_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      xor_q      <= xor_d;
      tmo_q      <= tmo_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      pkt_done_q <= pkt_done_d;
      pkt_err_q  <= pkt_err_d;
      err_code_q <= err_code_d;
      busy_q     <= (state_d != ST_IDLE);
      rx_drop_q  <= rx_drop_d;
    end
  end

  pkt_buf #(
    .DEPTH (MAX_LEN),
    .AW    (BAW)
  ) u_buf (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (BAW'(idx_q)),
    .wdata_i (rx_data),
    .raddr_i (buf_raddr),
    .rdata_o (buf_rdata)
  );

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign pkt_done = pkt_done_q;
  assign pkt_err  = pkt_err_q;
  assign err_code = err_code_q;
  assign busy     = busy_q;
  assign rx_drop  = rx_drop_q;

endmodule

// File: tb/tb_uart_pkt_ctrl.sv
// Self-checking bench for uart_pkt_ctrl: fixed frame table, hand-written
// corner sequences (drop, timeout, reset in commit) and random frames.
module tb_uart_pkt_ctrl;

  localparam int ML = 16;
  localparam int T  = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       pkt_done;
  logic       pkt_err;
  logic [1:0] err_code;
  logic       busy;
  logic       rx_drop;

  uart_pkt_ctrl #(
    .SYNC_BYTE   (8'hA5),
    .MAX_LEN     (ML),
    .TIMEOUT_CYC (T)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .pkt_done (pkt_done),
    .pkt_err  (pkt_err),
    .err_code (err_code),
    .busy     (busy),
    .rx_drop  (rx_drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observed activity since the last clear_mon.
  logic [7:0] wa_q[$];
  logic [7:0] wd_q[$];
  int         done_cnt = 0;
  int         err_cnt  = 0;
  int         drop_cnt = 0;
  int         last_code = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        wa_q.push_back(wr_addr);
        wd_q.push_back(wr_data);
      end
      if (pkt_done || pkt_err) begin
        checks++;
        if (pkt_done && pkt_err) begin
          errors++;
          $display("FAIL excl: pkt_done=%0d pkt_err=%0d, required not both high", pkt_done, pkt_err);
        end
      end
      if (pkt_done) done_cnt++;
      if (pkt_err) begin
        err_cnt++;
        last_code = int'(err_code);
      end
      if (rx_drop) drop_cnt++;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic clear_mon();
    wa_q.delete();
    wd_q.delete();
    done_cnt  = 0;
    err_cnt   = 0;
    drop_cnt  = 0;
    last_code = 0;
  endtask

  // Tasks below start and end 1ns after a rising edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_outcome(input string nm);
    for (int i = 0; i < 200 && (done_cnt + err_cnt) == 0; i++) idle(1);
    if ((done_cnt + err_cnt) == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_outcome: got no pkt_done/pkt_err in 200 cycles, expected one", nm);
    end
    idle(2);
  endtask

  // code 0 = expect commit of pl at base; otherwise expect pkt_err(code), no writes.
  task automatic check_frame(input string nm, input int code, input logic [7:0] base,
                             input logic [7:0] pl[$]);
    int nexp;
    logic [7:0] ea;
    nexp = (code == 0) ? pl.size() : 0;
    $display("frame %s: done=%0d err=%0d code=%0d writes=%0d", nm, done_cnt, err_cnt, last_code, wa_q.size());
    chk({nm, "_done"}, done_cnt, (code == 0) ? 1 : 0);
    chk({nm, "_err"}, err_cnt, (code == 0) ? 0 : 1);
    if (code != 0) chk({nm, "_code"}, last_code, code);
    chk({nm, "_nwr"}, wa_q.size(), nexp);
    for (int i = 0; i < nexp && i < wa_q.size(); i++) begin
      ea = base + 8'(i);
      chk($sformatf("%s_addr%0d", nm, i), wa_q[i], ea);
      chk($sformatf("%s_data%0d", nm, i), wd_q[i], pl[i]);
    end
  endtask

  function automatic logic [7:0] xor_of(input logic [7:0] q[$]);
    logic [7:0] x = 8'h00;
    foreach (q[i]) x ^= q[i];
    return x;
  endfunction

  function automatic logic [7:0] getb(input logic [63:0] b, input int k);
    return b[63-8*k -: 8];
  endfunction

  typedef struct packed {
    logic [63:0] b;     // bytes sent, first byte in the top octet
    logic [3:0]  n;     // number of bytes
    logic [1:0]  code;  // 0 = commit, else expected err_code
    logic [3:0]  nwr;   // expected write count
    logic [7:0]  a0;    // expected first write address
    logic [23:0] d;     // expected write data, first in the top octet
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] pl[$];
  logic [7:0] base, c, jb;
  int         kind, len, code;

  initial begin
    vecs[0] = '{b:64'hA5_10_03_11_22_33_13_00, n:4'd7, code:2'd0, nwr:4'd3, a0:8'h10, d:24'h11_22_33};
    vecs[1] = '{b:64'hA5_FE_03_01_02_03_FD_00, n:4'd7, code:2'd0, nwr:4'd3, a0:8'hFE, d:24'h01_02_03};
    vecs[2] = '{b:64'hA5_10_03_11_22_33_12_00, n:4'd7, code:2'd1, nwr:4'd0, a0:8'h00, d:24'h0};
    vecs[3] = '{b:64'hA5_00_00_00_00_00_00_00, n:4'd3, code:2'd2, nwr:4'd0, a0:8'h00, d:24'h0};
    vecs[4] = '{b:64'hA5_00_11_00_00_00_00_00, n:4'd3, code:2'd2, nwr:4'd0, a0:8'h00, d:24'h0};
    vecs[5] = '{b:64'h5A_77_A5_20_01_99_B8_00, n:4'd7, code:2'd0, nwr:4'd1, a0:8'h20, d:24'h99_00_00};

    // Asynchronous reset: outputs clear before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_pkt_done", pkt_done, 0);
    chk("rst_pkt_err", pkt_err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rx_drop", rx_drop, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Table of fixed frames.
    for (int v = 0; v < 6; v++) begin
      clear_mon();
      for (int k = 0; k < int'(vecs[v].n); k++) send_byte(getb(vecs[v].b, k));
      wait_outcome($sformatf("vec%0d", v));
      pl.delete();
      for (int i = 0; i < int'(vecs[v].nwr); i++) pl.push_back(vecs[v].d[23-8*i -: 8]);
      check_frame($sformatf("vec%0d", v), int'(vecs[v].code), vecs[v].a0, pl);
      chk($sformatf("vec%0d_busy", v), busy, 0);
    end

    // SYNC byte during COMMIT is dropped and starts nothing.
    clear_mon();
    for (int k = 0; k < 7; k++) send_byte(getb(vecs[0].b, k));
    send_byte(8'hA5);
    wait_outcome("drop");
    pl = '{8'h11, 8'h22, 8'h33};
    check_frame("drop", 0, 8'h10, pl);
    chk("drop_cnt", drop_cnt, 1);
    idle(3);
    chk("drop_busy", busy, 0);

    // Timeout after ADDR: error exactly T idle clocks after the last byte.
    clear_mon();
    send_byte(8'hA5);
    send_byte(8'h20);
    chk("tmo_busy_before", busy, 1);
    repeat (T - 1) @(posedge clk);
    @(negedge clk);
    chk("tmo_err_early", pkt_err, 0);
    @(posedge clk);
    @(negedge clk);
    chk("tmo_err", pkt_err, 1);
    chk("tmo_code", err_code, 3);
    @(posedge clk);
    #1;
    chk("tmo_busy_after", busy, 0);
    idle(2);

    // Byte arriving exactly at the expiry clock keeps the frame alive.
    clear_mon();
    send_byte(8'hA5);
    send_byte(8'h20);
    repeat (T - 1) @(posedge clk);
    #1;
    send_byte(8'h01);
    send_byte(8'h5C);
    send_byte(8'h7D);
    wait_outcome("keep");
    pl = '{8'h5C};
    check_frame("keep", 0, 8'h20, pl);

    // Reset in the middle of an 8-byte COMMIT.
    clear_mon();
    pl.delete();
    for (int i = 0; i < 8; i++) pl.push_back(8'(8'h11 * i + 1));
    send_byte(8'hA5);
    send_byte(8'hF0);
    send_byte(8'h08);
    foreach (pl[i]) send_byte(pl[i]);
    send_byte(8'hF0 ^ 8'h08 ^ xor_of(pl));
    send_byte(8'hA5);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(12);
    $display("frame midrst: done=%0d err=%0d writes=%0d drops=%0d", done_cnt, err_cnt, wa_q.size(), drop_cnt);
    chk("mid_rst_nwr", wa_q.size(), 3);
    chk("mid_rst_done", done_cnt, 0);
    chk("mid_rst_err", err_cnt, 0);
    chk("mid_rst_drop", drop_cnt, 1);
    for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
      chk($sformatf("mid_rst_addr%0d", i), wa_q[i], 8'hF0 + 8'(i));
      chk($sformatf("mid_rst_data%0d", i), wd_q[i], pl[i]);
    end

    // Random frames: valid, bad checksum, bad length; random gaps and junk.
    for (int f = 0; f < 40; f++) begin
      clear_mon();
      kind = $urandom_range(0, 3);
      base = 8'($urandom);
      pl.delete();
      if ($urandom_range(0, 3) == 0) begin
        jb = 8'($urandom);
        if (jb == 8'hA5) jb = 8'h00;
        send_byte(jb);
      end
      if (kind == 3) begin
        len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(ML + 1, 255);
        code = 2;
      end else begin
        len = $urandom_range(1, ML);
        code = (kind == 2) ? 1 : 0;
        for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      end
      send_byte(8'hA5);
      idle($urandom_range(0, 3));
      send_byte(base);
      idle($urandom_range(0, 3));
      send_byte(8'(len));
      if (kind != 3) begin
        foreach (pl[i]) begin
          idle($urandom_range(0, 3));
          send_byte(pl[i]);
        end
        c = base ^ 8'(len) ^ xor_of(pl);
        if (kind == 2) c = c ^ 8'h01;
        idle($urandom_range(0, 3));
        send_byte(c);
      end
      wait_outcome($sformatf("rnd%0d", f));
      check_frame($sformatf("rnd%0d", f), code, base, pl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
